// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shift engine with a CRC16-CCITT accumulator over either
// the transmitted (MOSI) or received (MISO) bit stream.
module spi_shift_engine #(
  parameter int unsigned SLOW_HALF = 35
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        start_write,
  input  logic        start_read,
  input  logic [7:0]  shift_in,
  output logic [7:0]  shift_out,
  input  logic [1:0]  speed,
  input  logic        crc_reset,
  input  logic        crc_source,
  output logic [15:0] crc_out,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a start strobe, sclk low, mosi high
  // SHIFT | byte in flight, sclk toggling every half-period
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hp_sel_q, hp_sel_d;
  logic [7:0]  hp_cnt_q, hp_cnt_d;
  logic [3:0]  tog_cnt_q, tog_cnt_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        crc_src_q, crc_src_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [15:0] crc_q, crc_d;

  logic        start;
  logic        expire;
  logic        rise;
  logic        fall;
  logic        last;
  logic        crc_bit;
  logic [15:0] crc_next;
  logic [7:0]  load_byte;
  logic [7:0]  hp_new;

  function automatic logic [7:0] hp_of(input logic [1:0] s);
    case (s)
      2'd0:    hp_of = 8'd1;
      2'd1:    hp_of = 8'd2;
      2'd2:    hp_of = 8'd4;
      default: hp_of = 8'(SLOW_HALF);
    endcase
  endfunction

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      hp_sel_q    <= 8'd1;
      hp_cnt_q    <= 8'd0;
      tog_cnt_q   <= 4'd0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      busy_q      <= 1'b0;
      crc_src_q   <= 1'b0;
      tx_q        <= 8'hFF;
      rx_q        <= 8'h00;
      shift_out_q <= 8'h00;
      crc_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      hp_sel_q    <= hp_sel_d;
      hp_cnt_q    <= hp_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      crc_src_q   <= crc_src_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      shift_out_q <= shift_out_d;
      crc_q       <= crc_d;
    end
  end

  assign start  = start_write | start_read;
  assign expire = (state_q == SHIFT) && (hp_cnt_q == 8'd0);
  assign rise   = expire && !sclk_q;
  assign fall   = expire && sclk_q;
  assign last   = fall && (tog_cnt_q == 4'd15);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CRC bit is the MOSI level presented at this rising edge, or MISO.
  assign crc_bit  = crc_src_q ? miso : mosi_q;
  assign crc_next = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ crc_bit) ? 16'h1021 : 16'h0000);
  assign load_byte = start_write ? shift_in : 8'hFF;
  assign hp_new    = hp_of(speed);

  always_comb begin
    hp_sel_d    = hp_sel_q;
    hp_cnt_d    = hp_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    crc_src_d   = crc_src_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    shift_out_d = shift_out_q;

    if (state_q == IDLE) begin
      if (start) begin
        tx_d      = load_byte;
        hp_sel_d  = hp_new;
        hp_cnt_d  = hp_new - 8'd1;
        tog_cnt_d = 4'd0;
        crc_src_d = crc_source;
        busy_d    = 1'b1;
        mosi_d    = load_byte[7];
        sclk_d    = 1'b0;
      end
    end else begin
      if (expire) begin
        hp_cnt_d  = hp_sel_q - 8'd1;
        tog_cnt_d = tog_cnt_q + 4'd1;
        sclk_d    = ~sclk_q;
      end else begin
        hp_cnt_d  = hp_cnt_q - 8'd1;
      end

      if (rise) rx_d = {rx_q[6:0], miso};

      if (last) begin
        shift_out_d = rx_q;
        mosi_d      = 1'b1;
        busy_d      = 1'b0;
      end else if (fall) begin
        tx_d   = {tx_q[6:0], 1'b0};
        mosi_d = tx_q[6];
      end
    end
  end

  always_comb begin
    crc_d = crc_q;
    if (crc_reset)  crc_d = 16'h0000;
    else if (rise)  crc_d = crc_next;
  end

  assign shift_out = shift_out_q;
  assign crc_out   = crc_q;
  assign mosi      = mosi_q;
  assign sclk      = sclk_q;
  assign busy      = busy_q;

endmodule
